mult_div_unit: RTL and testbench

//  Iterative-latency HI/LO multiply/divide unit for the E stage of the pipelined MIPS core.

---
 rtl/mult_div_unit_pkg.sv | 23 ++
 rtl/mdu_div_core.sv | 43 ++++
 rtl/mult_div_unit.sv | 93 +++++++++
 tb/tb_mult_div_unit.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// rtl/mult_div_unit_pkg.sv - opcode encoding and shared constants for the HI/LO multiply/divide unit
package mult_div_unit_pkg;

    typedef enum logic [2:0] {
        MDU_NOP   = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6,
        MDU_RSVD  = 3'd7
    } mdu_op_e;

    // Wide enough for any practical latency setting.
    localparam int CNT_W = 16;

    // Divide opcodes share the divider core and the divide latency.
    function automatic logic is_div_op(input mdu_op_e op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_div_core.sv
// rtl/mdu_div_core.sv - combinational 32-bit signed/unsigned divider with MIPS-style /0 and overflow results
module mdu_div_core
    import mult_div_unit_pkg::*;
(
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;

    // Divide magnitudes, then restore signs: quotient truncates toward zero, remainder follows the dividend.
    always_comb begin
        a_neg     = is_signed && dividend[31];
        b_neg     = is_signed && divisor[31];
        a_mag     = a_neg ? (32'd0 - dividend) : dividend;
        b_mag     = b_neg ? (32'd0 - divisor) : divisor;
        q_mag     = 32'd0;
        r_mag     = 32'd0;
        quotient  = 32'd0;
        remainder = 32'd0;
        if (divisor == 32'd0) begin
            quotient  = 32'hFFFF_FFFF;
            remainder = dividend;
        end else if (is_signed && dividend == 32'h8000_0000 && divisor == 32'hFFFF_FFFF) begin
            quotient  = 32'h8000_0000;
            remainder = 32'd0;
        end else begin
            q_mag     = a_mag / b_mag;
            r_mag     = a_mag % b_mag;
            quotient  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
            remainder = a_neg ? (32'd0 - r_mag) : r_mag;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - fixed-latency HI/LO multiply/divide unit with busy/done handshake
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic [CNT_W-1:0] counter;
    logic [31:0]      shadow_hi;
    logic [31:0]      shadow_lo;
    logic [63:0]      prod_s;
    logic [63:0]      prod_u;
    logic [31:0]      div_q;
    logic [31:0]      div_r;
    mdu_op_e          op_e;
    logic             accept;

    assign op_e = mdu_op_e'(op);
    assign busy = (counter != '0);

    // Requests arriving while an operation is pending are dropped, not queued.
    always_comb begin
        accept = start && !busy;
    end

    // Full-width products; the signed one uses sign-extended operands so the low 64 bits are exact.
    always_comb begin
        prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
        prod_u = {32'd0, rs_val} * {32'd0, rt_val};
    end

    mdu_div_core u_div_core (
        .is_signed (op_e == MDU_DIV),
        .dividend  (rs_val),
        .divisor   (rt_val),
        .quotient  (div_q),
        .remainder (div_r)
    );

    // Result is computed at accept into shadow regs and only made visible when the latency counter expires.
    always_ff @(posedge clk) begin
        if (!reset) begin
            counter   <= '0;
            shadow_hi <= 32'd0;
            shadow_lo <= 32'd0;
            hi        <= 32'd0;
            lo        <= 32'd0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (busy) begin
                counter <= counter - 1'b1;
                if (counter == CNT_W'(1)) begin
                    hi   <= shadow_hi;
                    lo   <= shadow_lo;
                    done <= 1'b1;
                end
            end else if (accept) begin
                case (op_e)
                    MDU_MULT: begin
                        {shadow_hi, shadow_lo} <= prod_s;
                        counter                <= CNT_W'(MUL_LAT);
                    end
                    MDU_MULTU: begin
                        {shadow_hi, shadow_lo} <= prod_u;
                        counter                <= CNT_W'(MUL_LAT);
                    end
                    MDU_DIV, MDU_DIVU: begin
                        shadow_hi <= div_r;
                        shadow_lo <= div_q;
                        counter   <= CNT_W'(DIV_LAT);
                    end
                    MDU_MTHI: hi <= rs_val;
                    MDU_MTLO: lo <= rs_val;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit with directed HI/LO vectors
module tb_mult_div_unit;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    int done_count = 0;
    int pushed = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    mult_div_unit #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expected {hi,lo}.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", {hi, lo}, 64'hX);
            end else begin
                check("result_hilo", {hi, lo}, exp_q.pop_front());
            end
        end
    end

    // Issue a MULT/DIV at a negedge, count busy cycles, optionally inject an ignored MULT at busy cycle inj.
    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input logic [31:0] eh, input logic [31:0] el, input int inj);
        logic [63:0] hold;
        logic        changed;
        int          n;
        exp_q.push_back({eh, el});
        pushed++;
        hold    = {hi, lo};
        changed = 1'b0;
        start   = 1'b1;
        op      = o;
        rs_val  = a;
        rt_val  = b;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            if ({hi, lo} !== hold) changed = 1'b1;
            if (n == inj) begin
                start  = 1'b1;
                op     = OP_MULT;
                rs_val = 32'h0000_0003;
                rt_val = 32'h0000_0004;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check({name, "_busy_cycles"}, 64'(n), 64'(lat));
        check({name, "_hold"}, 64'(changed), 64'd0);
    endtask

    initial begin
        int d0;
        reset  = 1'b0;
        start  = 1'b0;
        op     = OP_NOP;
        rs_val = 32'd0;
        rt_val = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", {30'd0, busy, done, hi, lo}, 96'd0);
        reset = 1'b1;
        @(negedge clk);

        run_op("mult_neg",   OP_MULT,  32'hFFFF_FFFF, 32'h0000_0002, MUL_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
        run_op("multu",      OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, MUL_LAT, 32'h0000_0001, 32'hFFFF_FFFE, 0);
        run_op("mult_min",   OP_MULT,  32'h8000_0000, 32'h8000_0000, MUL_LAT, 32'h4000_0000, 32'h0000_0000, 0);
        run_op("multu_max",  OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 32'hFFFF_FFFE, 32'h0000_0001, 0);
        run_op("div_neg",    OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, DIV_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        run_op("div_negdiv", OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, DIV_LAT, 32'h0000_0001, 32'hFFFF_FFFD, 0);
        run_op("divu_zero",  OP_DIVU,  32'h0000_0007, 32'h0000_0000, DIV_LAT, 32'h0000_0007, 32'hFFFF_FFFF, 0);
        run_op("div_zero",   OP_DIV,   32'hFFFF_FFFB, 32'h0000_0000, DIV_LAT, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 0);
        run_op("div_ovf",    OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT, 32'h0000_0000, 32'h8000_0000, 0);
        run_op("divu_big",   OP_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, DIV_LAT, 32'h0000_000F, 32'h0FFF_FFFF, 0);

        // MTHI / MTLO while idle: direct write, no busy, no done.
        start = 1'b1; op = OP_MTHI; rs_val = 32'h1234_5678;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("mthi", {busy, done, hi, lo}, {2'b00, 32'h1234_5678, 32'h0FFF_FFFF});
        start = 1'b1; op = OP_MTLO; rs_val = 32'hCAFE_F00D;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("mtlo", {busy, done, hi, lo}, {2'b00, 32'h1234_5678, 32'hCAFE_F00D});

        // NOP and reserved opcode with start: nothing changes.
        start = 1'b1; op = OP_NOP; rs_val = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 op = 3'd7;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("nop_rsvd", {busy, done, hi, lo}, {2'b00, 32'h1234_5678, 32'hCAFE_F00D});

        // MULT requested mid-DIV is ignored: one done, DIV result only.
        run_op("div_ign",    OP_DIV,   32'd100, 32'd7, DIV_LAT, 32'd2, 32'd14, 3);
        repeat (MUL_LAT + 3) @(negedge clk);
        check("ignored_start_idle", {busy, done}, 2'b00);

        // Reset during a DIV: nothing committed, no done afterwards.
        start = 1'b1; op = OP_DIV; rs_val = 32'd9; rt_val = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("mid_reset_state", {30'd0, busy, done, hi, lo}, 96'd0);
        d0 = done_count;
        repeat (20) @(negedge clk);
        check("mid_reset_no_done", 64'(done_count - d0), 64'd0);
        check("mid_reset_hilo", {hi, lo}, 64'd0);

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        check("done_total", 64'(done_count), 64'(pushed));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
